store_buffer: RTL
=================

Name: store_buffer

Overview:
Posted-write FIFO between the datapath store path and the single-port data memory (byte-addressed, 32-bit word read/write, write on posedge when MemWrite).
- Stores are accepted at one per cycle and retired to memory in order.
- Loads take priority for the memory address port and are forwarded from the youngest matching buffered store, so load results reflect program order.

Parameters:
DEPTH, 4, number of buffered stores; power of two, >= 2
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
st_valid  input  1  store request this cycle
st_addr  input  ADDR_W  store byte address
st_data  input  DATA_W  store data
st_ready  output  1  buffer can accept a store this cycle
ld_valid  input  1  load request this cycle (owns memory port)
ld_addr  input  ADDR_W  load byte address
ld_data  output  DATA_W  load result to datapath
ld_hit  output  1  ld_data taken from buffer, not memory
dm_rdata  input  DATA_W  memory read data (combinational from dm_addr)
dm_we  output  1  memory write enable (drives MemWrite)
dm_addr  output  ADDR_W  memory address
dm_din  output  DATA_W  memory write data
count  output  $clog2(DEPTH)+1  entries held
empty  output  1  count == 0
ovf_err  output  1  sticky: store presented while st_ready = 0

Behaviour:
- Reset (async, any time including mid-drain):
  - head = tail = count = 0; all entry addr/data = 0; ovf_err = 0.
  - Outputs follow: st_ready = 1, empty = 1, dm_we = 0, ld_hit = 0.
- Storage: circular array, pointers wrap modulo DEPTH. Push writes the tail entry then tail++. Pop does head++.
- st_ready = (count != DEPTH). This is purely registered state and does not look ahead on a same-cycle drain.
- Push: st_valid && st_ready at posedge. st_valid && !st_ready: store dropped, ovf_err <= 1 until reset.
- Memory port mux (combinational):
  - ld_valid = 1: dm_addr = ld_addr, dm_we = 0, dm_din = head data. No drain this cycle.
  - ld_valid = 0 && count > 0: dm_addr = head addr, dm_din = head data, dm_we = 1. Pop at the same posedge the memory writes. One store retires per cycle, so latency is 1 cycle per entry.
  - ld_valid = 0 && count == 0: dm_we = 0, dm_addr = 0, dm_din = 0.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged, both pointers advance.
  - At count = DEPTH a push is refused; a drain in that cycle still proceeds.
- Forwarding (combinational, ld_valid = 1):
  - Compare ld_addr against the address of every valid entry (exact full-address equality).
  - On a match, ld_hit = 1 and ld_data = data of the youngest matching entry, i.e. the one nearest tail.
  - No match: ld_hit = 0, ld_data = dm_rdata.
  - ld_valid = 0: ld_hit = 0, ld_data = dm_rdata.
- Same-cycle store and load to the same address: the store is not visible to that load; it forwards from the next cycle on.
- Misaligned stores (addr[1:0] != 0) are buffered and retired unchanged. Forwarding to them requires an identical address; partial overlap is not forwarded and is documented as unsupported.
- Ordering: memory writes occur strictly in push order. Buffered stores are never merged or reordered.
- Stall scenario: continuous ld_valid starves drain indefinitely; when full, st_ready = 0 and the datapath must stall.

Test Plan:
- Reset then push 0x10/0xAABBCCDD with ld_valid = 0 -> next cycle count = 1, dm_we = 1, dm_addr = 0x10, dm_din = 0xAABBCCDD; following cycle empty = 1, dm_we = 0, memory word 0x10 reads 0xAABBCCDD.
- Hold ld_valid = 1 (ld_addr = 0x40) and push 4 stores to 0x00, 0x04, 0x08, 0x0C -> count = 4, st_ready = 0, dm_we = 0. A 5th push -> dropped, ovf_err = 1. Release ld_valid -> 4 writes on 4 consecutive posedges in push order, then empty = 1.
- Buffer holds 0x20/0x11111111, then 0x20/0x22222222; load 0x20 -> ld_hit = 1, ld_data = 0x22222222. Load 0x24 -> ld_hit = 0, ld_data = dm_rdata.
- count = 1 with simultaneous push 0x30/0x5 and drain -> count stays 1, head entry written to memory, new entry at 0x30 retires next cycle.
- Wrap-around: 10 push/drain cycles at DEPTH = 4 -> pointers wrap, memory contents match the push sequence, count never exceeds 4.
- Assert reset mid-drain with count = 3 -> same instant dm_we = 0, count = 0, st_ready = 1, ovf_err = 0; no further memory writes.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer between the datapath store path and a single-port data memory.
// Loads own the memory port and forward from the youngest matching buffered store.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_hit,
  input  logic [DATA_W-1:0]        dm_rdata,
  output logic                     dm_we,
  output logic [ADDR_W-1:0]        dm_addr,
  output logic [DATA_W-1:0]        dm_din,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     cnt;
  logic              push, pop;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]     idx;

  assign st_ready = (cnt != FULL);
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign push     = st_valid && st_ready;
  assign pop      = !ld_valid && (cnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      ovf_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= st_addr;
        data_q[tail] <= st_data;
        tail         <= tail + PW'(1);
      end
      if (pop)
        head <= head + PW'(1);
      if (push && !pop)
        cnt <= cnt + CW'(1);
      else if (pop && !push)
        cnt <= cnt - CW'(1);
      if (st_valid && !st_ready)
        ovf_err <= 1'b1;
    end
  end

  // Walk oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < cnt) && (addr_q[idx] == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign ld_hit  = ld_valid && fwd_hit;
  assign ld_data = ld_hit ? fwd_data : dm_rdata;

  always_comb begin
    dm_we   = pop;
    dm_addr = '0;
    dm_din  = '0;
    if (ld_valid) begin
      dm_addr = ld_addr;
      dm_din  = data_q[head];
    end else if (cnt != '0) begin
      dm_addr = addr_q[head];
      dm_din  = data_q[head];
    end
  end

endmodule
